// File: rtl/storage_bridge_wb_pl.sv
// storage_bridge_wb_pl
//   Pipelined Wishbone slave that bridges the management core to RW_BLOCKS
//   read/write SRAM blocks and one read-only SRAM block.
//
//   Handshake: a request is taken when wb_cyc_i & wb_stb_i are high while the
//   bridge is idle; exactly one cycle of wb_ack_o (success) or wb_err_o
//   (unmapped address, or a write to the read-only block) answers each taken
//   request, unless wb_cyc_i drops while a read is waiting on the SRAM, in
//   which case no response is given. No request is taken in the response
//   cycle, so a strobe held through the ack starts a new transfer only after it.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, synchronous active-high reset
//   wb_adr_i .. wb_stb_i Wishbone slave request inputs
//   wb_ack_o, wb_err_o   one-cycle response strobes
//   wb_dat_o             registered read data, held until the next read capture
//   mgmt_ena/_wen        per-block active-low SRAM enable / write enable
//   mgmt_wen_mask        per-block active-high byte write mask
//   mgmt_addr/_wdata     shared SRAM word address and write data
//   mgmt_rdata           concatenated SRAM read data, block i at [i*32+:32]
//   mgmt_ena_ro          active-low read-only SRAM enable
//   mgmt_addr_ro         read-only SRAM word address
//   mgmt_rdata_ro        read-only SRAM read data
module storage_bridge_wb_pl #(
    parameter int          RW_BLOCKS    = 2,
    parameter int          ADDR_WIDTH   = 8,
    parameter int          RD_LATENCY   = 1,
    parameter logic [23:0] ADR_MASK     = 24'hFF_0000,
    parameter logic [23:0] RW_BASE      = 24'h00_0000,
    parameter logic [23:0] BLOCK_STRIDE = 24'h10_0000,
    parameter logic [23:0] RO_BASE      = 24'h20_0000
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [31:0]               wb_adr_i,
    input  logic [31:0]               wb_dat_i,
    input  logic [3:0]                wb_sel_i,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic [31:0]               wb_dat_o,
    output logic [RW_BLOCKS-1:0]      mgmt_ena,
    output logic [RW_BLOCKS-1:0]      mgmt_wen,
    output logic [RW_BLOCKS*4-1:0]    mgmt_wen_mask,
    output logic [ADDR_WIDTH-1:0]     mgmt_addr,
    output logic [31:0]               mgmt_wdata,
    input  logic [RW_BLOCKS*32-1:0]   mgmt_rdata,
    output logic                      mgmt_ena_ro,
    output logic [ADDR_WIDTH-1:0]     mgmt_addr_ro,
    input  logic [31:0]               mgmt_rdata_ro
);

    localparam int IDX_W = (RW_BLOCKS > 1) ? $clog2(RW_BLOCKS) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_WAIT = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;

    logic [1:0]           state;
    logic [1:0]           cnt;
    logic                 resp_err;
    logic                 rd_ro;
    logic [IDX_W-1:0]     rd_idx;

    logic [23:0]          m;
    logic [RW_BLOCKS-1:0] rw_hit;
    logic [IDX_W-1:0]     hit_idx;
    logic                 ro_hit;
    logic                 any_rw_hit;
    logic                 req;
    logic [31:0]          rd_data;

    // Address bits outside the decode window and the byte offset are ignored.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wb_adr_i[31:24], wb_adr_i[1:0]};

    // Region decode. Bases never overlap, so at most one hit bit is set and
    // the last-match index encode is unambiguous.
    always_comb begin
        m       = wb_adr_i[23:0] & ADR_MASK;
        rw_hit  = '0;
        hit_idx = '0;
        for (int i = 0; i < RW_BLOCKS; i++) begin
            if (m == RW_BASE + BLOCK_STRIDE * 24'(i)) begin
                rw_hit[i] = 1'b1;
                hit_idx   = IDX_W'(i);
            end
        end
        ro_hit     = (m == RO_BASE);
        any_rw_hit = |rw_hit;
    end

    // A request is only taken in IDLE; reset suppresses it so no strobe
    // reaches the SRAMs for a request that will not be tracked.
    assign req = (state == S_IDLE) && wb_cyc_i && wb_stb_i && !wb_rst_i;

    // Memory strobes are live only in the accept cycle.
    always_comb begin
        mgmt_ena      = '1;
        mgmt_wen      = '1;
        mgmt_wen_mask = '0;
        mgmt_ena_ro   = 1'b1;
        for (int i = 0; i < RW_BLOCKS; i++) begin
            if (req && rw_hit[i]) begin
                mgmt_ena[i] = 1'b0;
                mgmt_wen[i] = ~wb_we_i;
                if (wb_we_i) begin
                    mgmt_wen_mask[i*4 +: 4] = wb_sel_i;
                end
            end
        end
        if (req && ro_hit && !wb_we_i) begin
            mgmt_ena_ro = 1'b0;
        end
    end

    assign mgmt_addr    = wb_adr_i[ADDR_WIDTH+1:2];
    assign mgmt_addr_ro = wb_adr_i[ADDR_WIDTH+1:2];
    assign mgmt_wdata   = wb_dat_i;

    // Read-data select uses the target captured at accept time, since the
    // address may change while the read is outstanding.
    always_comb begin
        rd_data = mgmt_rdata_ro;
        if (!rd_ro) begin
            for (int i = 0; i < RW_BLOCKS; i++) begin
                if (int'(rd_idx) == i) begin
                    rd_data = mgmt_rdata[i*32 +: 32];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= S_IDLE;
            cnt      <= 2'd0;
            resp_err <= 1'b0;
            rd_ro    <= 1'b0;
            rd_idx   <= '0;
            wb_dat_o <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (any_rw_hit && wb_we_i) begin
                            state    <= S_RESP;
                            resp_err <= 1'b0;
                        end else if ((any_rw_hit || ro_hit) && !wb_we_i) begin
                            state  <= S_RD_WAIT;
                            cnt    <= 2'(RD_LATENCY - 1);
                            rd_ro  <= ro_hit && !any_rw_hit;
                            rd_idx <= hit_idx;
                        end else begin
                            // Unmapped address or write to the read-only block.
                            state    <= S_RESP;
                            resp_err <= 1'b1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    // An abandoned cycle wins over a completing read: the
                    // returning data is dropped and wb_dat_o is left alone.
                    if (!wb_cyc_i) begin
                        state <= S_IDLE;
                    end else if (cnt == 2'd0) begin
                        wb_dat_o <= rd_data;
                        state    <= S_RESP;
                        resp_err <= 1'b0;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_ack_o = (state == S_RESP) && !resp_err;
    assign wb_err_o = (state == S_RESP) && resp_err;

endmodule

// File: tb/tb_storage_bridge_wb_pl.sv
module tb_storage_bridge_wb_pl;

    localparam int L = 2;

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_WACK = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;
    localparam logic [1:0] K_RACK = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] wb_dat_o;
    logic [1:0]  mgmt_ena;
    logic [1:0]  mgmt_wen;
    logic [7:0]  mgmt_wen_mask;
    logic [7:0]  mgmt_addr;
    logic [31:0] mgmt_wdata;
    logic [63:0] mgmt_rdata;
    logic        mgmt_ena_ro;
    logic [7:0]  mgmt_addr_ro;
    logic [31:0] mgmt_rdata_ro;

    int total = 0;
    int bad   = 0;
    int ena_pulses = 0;
    int p0;
    logic [31:0] last_dat;

    logic [33:0] exp_q[$];

    logic [31:0] rw_mem[2][256];
    logic [31:0] ro_mem[256];
    logic [31:0] pipe_rw[2][2];
    logic [31:0] pipe_ro0, pipe_ro1;
    logic [31:0] shadow[2][4];

    storage_bridge_wb_pl #(
        .RW_BLOCKS (2),
        .ADDR_WIDTH(8),
        .RD_LATENCY(L)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .wb_adr_i     (adr),
        .wb_dat_i     (dat),
        .wb_sel_i     (sel),
        .wb_we_i      (we),
        .wb_cyc_i     (cyc),
        .wb_stb_i     (stb),
        .wb_ack_o     (wb_ack_o),
        .wb_err_o     (wb_err_o),
        .wb_dat_o     (wb_dat_o),
        .mgmt_ena     (mgmt_ena),
        .mgmt_wen     (mgmt_wen),
        .mgmt_wen_mask(mgmt_wen_mask),
        .mgmt_addr    (mgmt_addr),
        .mgmt_wdata   (mgmt_wdata),
        .mgmt_rdata   (mgmt_rdata),
        .mgmt_ena_ro  (mgmt_ena_ro),
        .mgmt_addr_ro (mgmt_addr_ro),
        .mgmt_rdata_ro(mgmt_rdata_ro)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // SRAM models: L-stage read pipeline, byte-masked writes.
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (!mgmt_ena[b] && !mgmt_wen[b]) begin
                for (int j = 0; j < 4; j++) begin
                    if (mgmt_wen_mask[b*4+j]) rw_mem[b][mgmt_addr][j*8 +: 8] = mgmt_wdata[j*8 +: 8];
                end
            end
            pipe_rw[b][0] <= (!mgmt_ena[b] && mgmt_wen[b]) ? rw_mem[b][mgmt_addr] : 32'hBAD0_0000;
            pipe_rw[b][1] <= pipe_rw[b][0];
        end
        pipe_ro0 <= !mgmt_ena_ro ? ro_mem[mgmt_addr_ro] : 32'hBAD0_0001;
        pipe_ro1 <= pipe_ro0;
    end

    assign mgmt_rdata    = {pipe_rw[1][1], pipe_rw[0][1]};
    assign mgmt_rdata_ro = pipe_ro1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: responses popped against expectations in issue order.
    always @(negedge clk) begin
        logic [33:0] e;
        if (mgmt_ena != 2'b11 || !mgmt_ena_ro) ena_pulses++;
        if (wb_ack_o && wb_err_o) check("ack_err_excl", 32'd1, 32'd0);
        if (wb_ack_o || wb_err_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_resp", {30'd0, wb_err_o, wb_ack_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_kind", {30'd0, wb_err_o, wb_ack_o},
                      (e[33:32] == K_ERR) ? 32'd2 : 32'd1);
                if (e[33:32] == K_RACK) check("rd_data", wb_dat_o, e[31:0]);
            end
        end
    end

    // Drivers
    task automatic xfer_start(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic w, input logic [1:0] kind, input logic [31:0] exp_d);
        if (kind != K_NONE) exp_q.push_back({kind, exp_d});
        if (kind == K_RACK) last_dat = exp_d;
        p0 = ena_pulses;
        @(posedge clk); #1;
        adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
    endtask

    task automatic xfer_finish(input string tag, input int exp_lat, input int exp_pulse);
        int lat;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check({tag, "_pulses"}, ena_pulses - p0, exp_pulse);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        xfer_start(a, d, s, 1'b1, K_WACK, 32'h0);
        xfer_finish(tag, 1, 1);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d);
        xfer_start(a, 32'h0, 4'h0, 1'b0, K_RACK, exp_d);
        xfer_finish(tag, L + 1, 1);
    endtask

    initial begin
        int acks;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 256; i++) rw_mem[b][i] = 32'h0;
            for (int i = 0; i < 4; i++) shadow[b][i] = 32'h0;
        end
        for (int i = 0; i < 256; i++) ro_mem[i] = 32'h0;
        rw_mem[0][1] = 32'h1234_5678;
        rw_mem[0][5] = 32'hAAAA_AAAA;
        ro_mem[0]    = 32'hCAFE_F00D;
        last_dat = 32'h0;

        rst = 1'b1; adr = 32'h0; dat = 32'h0; sel = 4'h0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", wb_ack_o, 1'b0);
        check("rst_err", wb_err_o, 1'b0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_ena", mgmt_ena, 2'b11);
        check("rst_ena_ro", mgmt_ena_ro, 1'b1);
        check("rst_mask", mgmt_wen_mask, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;

        // Write to block 1 word 2: strobes in T, ack in T+1
        xfer_start(32'h0010_0008, 32'hDEAD_BEEF, 4'hF, 1'b1, K_WACK, 32'h0);
        check("w1_ena", mgmt_ena, 2'b01);
        check("w1_wen", mgmt_wen, 2'b01);
        check("w1_addr", mgmt_addr, 8'h02);
        check("w1_mask", mgmt_wen_mask, 8'hF0);
        check("w1_wdata", mgmt_wdata, 32'hDEAD_BEEF);
        xfer_finish("w1", 1, 1);

        // Read block 0 word 1
        xfer_start(32'h0000_0004, 32'h0, 4'h0, 1'b0, K_RACK, 32'h1234_5678);
        check("r0_ena", mgmt_ena, 2'b10);
        check("r0_wen", mgmt_wen, 2'b11);
        check("r0_ena_ro", mgmt_ena_ro, 1'b1);
        xfer_finish("r0", L + 1, 1);

        // Read the read-only block
        xfer_start(32'h0020_0000, 32'h0, 4'h0, 1'b0, K_RACK, 32'hCAFE_F00D);
        check("ro_ena_ro", mgmt_ena_ro, 1'b0);
        check("ro_ena", mgmt_ena, 2'b11);
        xfer_finish("ro", L + 1, 1);

        // Write to read-only block and read an unmapped region -> err
        xfer_start(32'h0020_0000, 32'h1111_1111, 4'hF, 1'b1, K_ERR, 32'h0);
        check("ewr_ena", mgmt_ena, 2'b11);
        check("ewr_wen", mgmt_wen, 2'b11);
        check("ewr_mask", mgmt_wen_mask, 8'h00);
        xfer_finish("ewr", 1, 0);
        xfer_start(32'h0030_0000, 32'h0, 4'h0, 1'b0, K_ERR, 32'h0);
        check("erd_ena_ro", mgmt_ena_ro, 1'b1);
        xfer_finish("erd", 1, 0);

        // Written data reaches the SRAM; partial byte-lane write
        rd("rb1", 32'h0010_0008, 32'hDEAD_BEEF);
        wr("wp", 32'h0000_0014, 32'h1122_3344, 4'b0101);
        rd("rp", 32'h0000_0014, 32'hAA22_AA44);

        // Strobe held for four cycles: two writes, acks at T+1 and T+3
        exp_q.push_back({K_WACK, 32'h0});
        exp_q.push_back({K_WACK, 32'h0});
        p0 = ena_pulses;
        @(posedge clk); #1;
        adr = 32'h0000_000C; dat = 32'h0000_0055; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("b2b_ack", wb_ack_o, (k % 2 == 1) ? 1'b1 : 1'b0);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("b2b_pulses", ena_pulses - p0, 2);

        // Abort: cyc dropped in RD_WAIT -> no response, old data kept
        xfer_start(32'h0000_0004, 32'h0, 4'h0, 1'b0, K_NONE, 32'h0);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) acks++;
        end
        check("abort_noresp", acks, 0);
        check("abort_dat", wb_dat_o, last_dat);
        rd("after_abort", 32'h0020_0000, 32'hCAFE_F00D);

        // Reset during RD_WAIT
        xfer_start(32'h0010_0008, 32'h0, 4'h0, 1'b0, K_NONE, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_ack", wb_ack_o, 1'b0);
        check("mrst_err", wb_err_o, 1'b0);
        check("mrst_dat", wb_dat_o, 32'h0);
        check("mrst_ena", mgmt_ena, 2'b11);
        rd("after_rst", 32'h0010_0008, 32'hDEAD_BEEF);

        // Random traffic over a private window, checked against a shadow copy
        for (int n = 0; n < 24; n++) begin
            int b, w;
            logic [31:0] a, d;
            logic [3:0] s;
            b = $urandom_range(0, 1);
            w = $urandom_range(0, 3);
            a = (b == 1 ? 32'h0010_0000 : 32'h0) + 32'((16 + w) * 4);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(1, 15));
                for (int j = 0; j < 4; j++) if (s[j]) shadow[b][w][j*8 +: 8] = d[j*8 +: 8];
                wr("rnd_wr", a, d, s);
            end else begin
                rd("rnd_rd", a, shadow[b][w]);
            end
        end

        repeat (4) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
